ccff_chain_loader: RTL and testbench

//  Sequences configuration of a ble4-style logic element's configuration-flip-flop (ccff) chain.
//  The chain holds 16 LUT4 truth-table bits followed by 2 output-mux select bits.

---
 rtl/ccff_chain_loader.sv | 130 +++++++++++++
 tb/tb_ccff_chain_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: accepts host config words over valid/ready and shifts
// them LSB-first into a ble4 configuration-flip-flop chain, with an optional
// verify pass that compares the chain tail against the re-sent stream.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 18,
  parameter int WORD_W    = 8,
  localparam int CNT_W    = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_FIN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WORD_W-1:0] r_sreg;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [CNT_W-1:0]  r_total_cnt;
  logic              r_head;
  logic              r_shift_en;
  logic              r_verify;
  logic              r_error;
  logic              r_busy;

  logic w_accept;
  logic w_handshake;
  logic w_last_bit;
  logic w_word_end;
  logic w_done;

  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_handshake = (r_state == S_FETCH) && cfg_valid;
  assign w_last_bit  = (r_total_cnt == CNT_W'(CHAIN_LEN - 1));
  assign w_word_end  = (r_bit_idx == IDX_W'(WORD_W - 1));
  // FIN holds until the final registered shift_en has been consumed by the chain
  assign w_done      = (r_state == S_FIN) && !r_shift_en;

  assign cfg_ready     = (r_state == S_FETCH);
  assign ccff_head     = r_head;
  assign ccff_shift_en = r_shift_en;
  assign busy          = r_busy;
  assign done          = w_done;
  assign error         = r_error;

  // State register
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: if (cfg_valid) w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_last_bit) begin
          w_next = S_FIN;
        end else if (w_word_end) begin
          w_next = S_FETCH;
        end
      end
      S_FIN:   if (!r_shift_en) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Word capture, serializer, counters, status flags and verify compare
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      r_sreg      <= '0;
      r_bit_idx   <= '0;
      r_total_cnt <= '0;
      r_head      <= 1'b0;
      r_shift_en  <= 1'b0;
      r_verify    <= 1'b0;
      r_error     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_shift_en <= (r_state == S_SHIFT);
      if (r_state == S_SHIFT) begin
        r_head      <= r_sreg[r_bit_idx];
        r_bit_idx   <= r_bit_idx + IDX_W'(1);
        r_total_cnt <= r_total_cnt + CNT_W'(1);
      end
      if (w_handshake) begin
        r_sreg    <= cfg_data;
        r_bit_idx <= '0;
      end
      // Tail shows the bit shifted in CHAIN_LEN shifts ago, i.e. the same
      // stream position of the previous load, so it must equal head.
      if (r_verify && r_shift_en && (ccff_tail != r_head)) begin
        r_error <= 1'b1;
      end
      if (w_accept) begin
        r_verify    <= verify;
        r_error     <= 1'b0;
        r_busy      <= 1'b1;
        r_total_cnt <= '0;
      end
      if (w_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader: table of load/verify operations
// on an 18-bit chain plus directed sequences for reset, and a 5-bit chain.
module tb_ccff_chain_loader;

  localparam int L  = 18;
  localparam int W  = 8;
  localparam int L5 = 5;

  logic prog_clk = 1'b0;
  logic prog_rst_n = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Main DUT (18-bit chain)
  logic         start = 1'b0, verify = 1'b0, cfg_valid = 1'b0;
  logic [W-1:0] cfg_data = '0;
  logic         cfg_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, error;

  // Short-chain DUT (5-bit chain)
  logic         start5 = 1'b0, verify5 = 1'b0, cfg_valid5 = 1'b0;
  logic [W-1:0] cfg_data5 = '0;
  logic         cfg_ready5, ccff_head5, ccff_shift_en5, ccff_tail5, busy5, done5, error5;

  ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) u_dut (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start), .verify(verify),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .error(error)
  );

  ccff_chain_loader #(.CHAIN_LEN(L5), .WORD_W(W)) u_dut5 (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start5), .verify(verify5),
    .cfg_data(cfg_data5), .cfg_valid(cfg_valid5), .cfg_ready(cfg_ready5),
    .ccff_head(ccff_head5), .ccff_shift_en(ccff_shift_en5), .ccff_tail(ccff_tail5),
    .busy(busy5), .done(done5), .error(error5)
  );

  // Chain models: index 0 is the first flop, index L-1 drives the tail
  logic [L-1:0]  chain;
  logic [L5-1:0] chain5;
  assign ccff_tail  = chain[L-1];
  assign ccff_tail5 = chain5[L5-1];

  always @(posedge prog_clk) begin
    if (ccff_shift_en)  chain  <= {chain[L-2:0], ccff_head};
    if (ccff_shift_en5) chain5 <= {chain5[L5-2:0], ccff_head5};
  end

  // Event monitors, sampled mid-cycle for the upcoming edge
  int   hs_cnt = 0, sh_cnt = 0, hs5_cnt = 0, sh5_cnt = 0;
  logic stream_log [0:1023];

  always @(negedge prog_clk) begin
    if (cfg_valid && cfg_ready) hs_cnt <= hs_cnt + 1;
    if (ccff_shift_en) begin
      stream_log[sh_cnt % 1024] <= ccff_head;
      sh_cnt <= sh_cnt + 1;
    end
    if (cfg_valid5 && cfg_ready5) hs5_cnt <= hs5_cnt + 1;
    if (ccff_shift_en5) sh5_cnt <= sh5_cnt + 1;
  end

  int   checks = 0;
  int   errors = 0;
  logic prev_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        vfy;
    logic [7:0]  w0, w1, w2;
    int          gap;          // cycles cfg_valid is low before each word
    logic        poke;         // pulse start once while shifting
    logic [17:0] exp_stream;   // bit k = k-th head bit shifted
    logic        exp_err;
    int          exp_cycles;   // FETCH entry to done inclusive; 0 = skip
    logic        chk_chain;
  } vec_t;

  vec_t tbl [6];

  task automatic run_op(input vec_t v, input string tag);
    int          hs0, sh0, done_cyc, wi, gapc;
    logic        poke_next, err_at_done, busy_at_done;
    logic [7:0]  words [3];
    logic [17:0] got;
    logic [L-1:0] exp_chain;
    hs0 = hs_cnt; sh0 = sh_cnt; done_cyc = 0; wi = 0; gapc = v.gap;
    poke_next = 1'b0; err_at_done = 1'b0; busy_at_done = 1'b0;
    words[0] = v.w0; words[1] = v.w1; words[2] = v.w2;
    chk({tag, " err_sticky_idle"}, error, prev_err);
    start = 1'b1; verify = v.vfy; cfg_valid = 1'b0;
    @(posedge prog_clk); #1;
    start = 1'b0; verify = 1'b0;
    for (int cyc = 1; cyc <= 200 && done_cyc == 0; cyc++) begin
      start = poke_next; poke_next = 1'b0;
      if (wi < 3 && gapc > 0) begin
        cfg_valid = 1'b0;
      end else if (wi < 3) begin
        cfg_valid = 1'b1; cfg_data = words[wi];
      end else begin
        // extra words stay offered; any further fetch would be an error
        cfg_valid = (v.gap == 0); cfg_data = 8'hFF;
      end
      @(negedge prog_clk);
      if (cyc == 1) begin
        chk({tag, " err_clr"}, error, 1'b0);
        chk({tag, " busy_on"}, busy, 1'b1);
      end
      if (done) begin
        done_cyc = cyc; err_at_done = error; busy_at_done = busy;
      end else if (cfg_valid && cfg_ready) begin
        wi++; gapc = v.gap;
        if (wi == 1 && v.poke) poke_next = 1'b1;
      end else if (!cfg_valid && gapc > 0) begin
        gapc--;
      end
      @(posedge prog_clk); #1;
    end
    cfg_valid = 1'b0; start = 1'b0;
    chk({tag, " done_seen"}, (done_cyc != 0), 1'b1);
    @(negedge prog_clk); #1;
    chk({tag, " done_1cyc"}, done, 1'b0);
    chk({tag, " busy_off"}, {busy_at_done, busy}, 2'b10);
    chk({tag, " handshakes"}, hs_cnt - hs0, 3);
    chk({tag, " shifts"}, sh_cnt - sh0, L);
    for (int k = 0; k < L; k++) got[k] = stream_log[(sh0 + k) % 1024];
    chk({tag, " head_stream"}, got, v.exp_stream);
    chk({tag, " err_at_done"}, err_at_done, v.exp_err);
    chk({tag, " err_held"}, error, v.exp_err);
    if (v.exp_cycles != 0) chk({tag, " latency"}, done_cyc, v.exp_cycles);
    if (v.chk_chain) begin
      for (int k = 0; k < L; k++) exp_chain[L-1-k] = v.exp_stream[k];
      chk({tag, " chain"}, chain, exp_chain);
    end
    prev_err = v.exp_err;
    @(posedge prog_clk); #1;
  endtask

  initial begin
    int sh0, done_cyc, hs0;
    //            vfy   w0     w1     w2    gap poke stream       err  cyc chain
    tbl[0] = '{1'b0, 8'hA5, 8'h3C, 8'h02, 0, 1'b0, 18'h23CA5, 1'b0, 23, 1'b1};
    tbl[1] = '{1'b1, 8'hA5, 8'h3C, 8'h02, 0, 1'b0, 18'h23CA5, 1'b0, 23, 1'b1};
    tbl[2] = '{1'b1, 8'hA5, 8'h3D, 8'h02, 0, 1'b0, 18'h23DA5, 1'b1, 23, 1'b0};
    tbl[3] = '{1'b0, 8'hA5, 8'h3C, 8'h02, 5, 1'b0, 18'h23CA5, 1'b0, 0,  1'b1};
    tbl[4] = '{1'b0, 8'hA5, 8'h3C, 8'h02, 0, 1'b1, 18'h23CA5, 1'b0, 23, 1'b1};
    tbl[5] = '{1'b1, 8'hA5, 8'h3C, 8'h02, 0, 1'b0, 18'h23CA5, 1'b0, 23, 1'b1};

    // Reset state
    #1;
    chk("rst_outputs", {cfg_ready, ccff_head, ccff_shift_en, busy, done, error}, 6'b0);
    chk("rst_outputs5", {cfg_ready5, ccff_head5, ccff_shift_en5, busy5, done5, error5}, 6'b0);
    repeat (2) @(posedge prog_clk);
    #1 prog_rst_n = 1'b1;
    @(posedge prog_clk); #1;

    for (int i = 0; i < 6; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of shifting, then a full reload
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0; cfg_valid = 1'b1; cfg_data = 8'hA5;
    sh0 = sh_cnt;
    for (int t = 0; t < 50 && (sh_cnt - sh0) < 7; t++) begin
      @(negedge prog_clk); #1;
    end
    chk("midrst_shifts_seen", sh_cnt - sh0, 7);
    chk("midrst_shift_active", ccff_shift_en, 1'b1);
    prog_rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {cfg_ready, ccff_head, ccff_shift_en, busy, done, error}, 6'b0);
    cfg_valid = 1'b0;
    @(posedge prog_clk); #1;
    prog_rst_n = 1'b1;
    @(negedge prog_clk);
    chk("midrst_idle", {cfg_ready, ccff_shift_en, busy}, 3'b0);
    @(posedge prog_clk); #1;
    prev_err = 1'b0;
    run_op(tbl[0], "reload");

    // 5-bit chain with an 8-bit word: one fetch, upper bits dropped
    hs0 = hs5_cnt; sh0 = sh5_cnt; done_cyc = 0;
    start5 = 1'b1;
    @(posedge prog_clk); #1;
    start5 = 1'b0; cfg_valid5 = 1'b1; cfg_data5 = 8'hFF;
    for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
      @(negedge prog_clk);
      if (done5) done_cyc = cyc;
      @(posedge prog_clk); #1;
    end
    cfg_valid5 = 1'b0;
    @(negedge prog_clk); #1;
    chk("c5 done_seen", (done_cyc != 0), 1'b1);
    chk("c5 latency", done_cyc, L5 + 1 + 2);
    chk("c5 handshakes", hs5_cnt - hs0, 1);
    chk("c5 shifts", sh5_cnt - sh0, L5);
    chk("c5 chain", chain5, 5'h1F);
    chk("c5 idle", {busy5, done5, error5}, 3'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
